// File: rtl/fetch_queue.sv
// Purpose:      two-wide instruction fetch queue between prediction/fetch and decode.
// Latency:      enqueued entries appear on deq_* the cycle after the write edge (no bypass).
// Backpressure: enq_ready = at least two free entries; bundles offered while not ready are dropped.
// Ports: CLK/reset (async active-low); flush empties queue; enq_* = 2-slot fetch bundle
//        (slot 1 PC = enq_pc+4); deq_pop = entries consumed (0..2, clamped to count);
//        deq_*0/1 = head / head+1 payload (first-word fall-through); count = occupancy.
module fetch_queue #(
  parameter int XLEN        = 32,
  parameter int PHT_ADDRESS = 9,
  parameter int GHR_SIZE    = 9,
  parameter int DEPTH       = 8
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic [31:0]              enq_instr0,
  input  logic [31:0]              enq_instr1,
  input  logic                     enq_slot1_valid,
  input  logic                     enq_pred_taken0,
  input  logic                     enq_pred_taken1,
  input  logic                     enq_btb_hit0,
  input  logic                     enq_btb_hit1,
  input  logic [XLEN-1:0]          enq_pred_target0,
  input  logic [XLEN-1:0]          enq_pred_target1,
  input  logic [PHT_ADDRESS-1:0]   enq_pht_index0,
  input  logic [PHT_ADDRESS-1:0]   enq_pht_index1,
  input  logic [GHR_SIZE-1:0]      enq_ghr,
  input  logic [1:0]               deq_pop,
  output logic                     deq_valid0,
  output logic                     deq_valid1,
  output logic [XLEN-1:0]          deq_pc0,
  output logic [XLEN-1:0]          deq_pc1,
  output logic [31:0]              deq_instr0,
  output logic [31:0]              deq_instr1,
  output logic                     deq_pred_taken0,
  output logic                     deq_pred_taken1,
  output logic                     deq_btb_hit0,
  output logic                     deq_btb_hit1,
  output logic [XLEN-1:0]          deq_pred_target0,
  output logic [XLEN-1:0]          deq_pred_target1,
  output logic [PHT_ADDRESS-1:0]   deq_pht_index0,
  output logic [PHT_ADDRESS-1:0]   deq_pht_index1,
  output logic [GHR_SIZE-1:0]      deq_ghr0,
  output logic [GHR_SIZE-1:0]      deq_ghr1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [31:0]            instr;
    logic                   pred_taken;
    logic                   btb_hit;
    logic [XLEN-1:0]        pred_target;
    logic [PHT_ADDRESS-1:0] pht_index;
    logic [GHR_SIZE-1:0]    ghr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   count_q;

  logic [1:0]      pop_req;
  logic [1:0]      n_pop;
  logic [1:0]      n_enq;
  logic            enq_fire;
  entry_t          wr0;
  entry_t          wr1;
  entry_t          rd0;
  entry_t          rd1;

  // Pop request 3 means "two"; then clamp to what is actually held. When the
  // clamp applies, count is 0 or 1, so its low two bits are the exact value.
  assign pop_req = deq_pop[1] ? 2'd2 : deq_pop;
  assign n_pop   = (CW'(pop_req) > count_q) ? count_q[1:0] : pop_req;

  // Ready looks only at the pre-update count, so a slot freed by a pop in the
  // same cycle is never reused in that cycle.
  assign enq_ready = (count_q <= CW'(DEPTH - 2));
  assign enq_fire  = enq_valid && enq_ready && !flush;
  assign n_enq     = enq_fire ? (enq_slot1_valid ? 2'd2 : 2'd1) : 2'd0;

  always_comb begin
    wr0             = '0;
    wr0.pc          = enq_pc;
    wr0.instr       = enq_instr0;
    wr0.pred_taken  = enq_pred_taken0;
    wr0.btb_hit     = enq_btb_hit0;
    wr0.pred_target = enq_pred_target0;
    wr0.pht_index   = enq_pht_index0;
    wr0.ghr         = enq_ghr;
    wr1             = '0;
    wr1.pc          = enq_pc + XLEN'(4);
    wr1.instr       = enq_instr1;
    wr1.pred_taken  = enq_pred_taken1;
    wr1.btb_hit     = enq_btb_hit1;
    wr1.pred_target = enq_pred_target1;
    wr1.pht_index   = enq_pht_index1;
    wr1.ghr         = enq_ghr;
  end

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Storage is left as-is; only the bookkeeping is discarded.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(n_pop);
      tail_q  <= tail_q + PW'(n_enq);
      count_q <= count_q + CW'(n_enq) - CW'(n_pop);
      if (enq_fire) mem[tail_q] <= wr0;
      if (enq_fire && enq_slot1_valid) mem[tail_q + PW'(1)] <= wr1;
    end
  end

  assign rd0 = mem[head_q];
  assign rd1 = mem[head_q + PW'(1)];

  assign deq_valid0       = (count_q != '0);
  assign deq_valid1       = (count_q >= CW'(2));
  assign deq_pc0          = rd0.pc;
  assign deq_pc1          = rd1.pc;
  assign deq_instr0       = rd0.instr;
  assign deq_instr1       = rd1.instr;
  assign deq_pred_taken0  = rd0.pred_taken;
  assign deq_pred_taken1  = rd1.pred_taken;
  assign deq_btb_hit0     = rd0.btb_hit;
  assign deq_btb_hit1     = rd1.btb_hit;
  assign deq_pred_target0 = rd0.pred_target;
  assign deq_pred_target1 = rd1.pred_target;
  assign deq_pht_index0   = rd0.pht_index;
  assign deq_pht_index1   = rd1.pht_index;
  assign deq_ghr0         = rd0.ghr;
  assign deq_ghr1         = rd1.ghr;
  assign count            = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Purpose:      randomized + directed self-checking bench for fetch_queue.
// Latency:      outputs sampled on the falling edge, one model step per rising edge.
// Backpressure: model drops bundles whenever fewer than two entries are free.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        reset;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_instr0, enq_instr1;
  logic        enq_slot1_valid;
  logic        enq_pred_taken0, enq_pred_taken1;
  logic        enq_btb_hit0, enq_btb_hit1;
  logic [31:0] enq_pred_target0, enq_pred_target1;
  logic [8:0]  enq_pht_index0, enq_pht_index1;
  logic [8:0]  enq_ghr;
  logic [1:0]  deq_pop;
  logic        deq_valid0, deq_valid1;
  logic [31:0] deq_pc0, deq_pc1;
  logic [31:0] deq_instr0, deq_instr1;
  logic        deq_pred_taken0, deq_pred_taken1;
  logic        deq_btb_hit0, deq_btb_hit1;
  logic [31:0] deq_pred_target0, deq_pred_target1;
  logic [8:0]  deq_pht_index0, deq_pht_index1;
  logic [8:0]  deq_ghr0, deq_ghr1;
  logic [3:0]  count;

  always #5 CLK = ~CLK;

  fetch_queue dut (
    .CLK(CLK), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_instr0(enq_instr0), .enq_instr1(enq_instr1), .enq_slot1_valid(enq_slot1_valid),
    .enq_pred_taken0(enq_pred_taken0), .enq_pred_taken1(enq_pred_taken1),
    .enq_btb_hit0(enq_btb_hit0), .enq_btb_hit1(enq_btb_hit1),
    .enq_pred_target0(enq_pred_target0), .enq_pred_target1(enq_pred_target1),
    .enq_pht_index0(enq_pht_index0), .enq_pht_index1(enq_pht_index1),
    .enq_ghr(enq_ghr), .deq_pop(deq_pop),
    .deq_valid0(deq_valid0), .deq_valid1(deq_valid1),
    .deq_pc0(deq_pc0), .deq_pc1(deq_pc1),
    .deq_instr0(deq_instr0), .deq_instr1(deq_instr1),
    .deq_pred_taken0(deq_pred_taken0), .deq_pred_taken1(deq_pred_taken1),
    .deq_btb_hit0(deq_btb_hit0), .deq_btb_hit1(deq_btb_hit1),
    .deq_pred_target0(deq_pred_target0), .deq_pred_target1(deq_pred_target1),
    .deq_pht_index0(deq_pht_index0), .deq_pht_index1(deq_pht_index1),
    .deq_ghr0(deq_ghr0), .deq_ghr1(deq_ghr1), .count(count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic        hit;
    logic [31:0] target;
    logic [8:0]  pht;
    logic [8:0]  ghr;
  } ent_t;

  ent_t mq[$];
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of entries; the next state follows from the current
  // inputs and the current occupancy only.
  task automatic model_step();
    int   sz;
    int   preq;
    int   np;
    ent_t e;
    sz = mq.size();
    if (!reset) return;
    if (flush) begin
      mq.delete();
      return;
    end
    preq = (deq_pop >= 2'd2) ? 2 : int'(deq_pop);
    np   = (preq > sz) ? sz : preq;
    for (int k = 0; k < np; k++) void'(mq.pop_front());
    if (enq_valid && (8 - sz) >= 2) begin
      e.pc = enq_pc; e.instr = enq_instr0; e.taken = enq_pred_taken0; e.hit = enq_btb_hit0;
      e.target = enq_pred_target0; e.pht = enq_pht_index0; e.ghr = enq_ghr;
      mq.push_back(e);
      if (enq_slot1_valid) begin
        e.pc = enq_pc + 32'd4; e.instr = enq_instr1; e.taken = enq_pred_taken1;
        e.hit = enq_btb_hit1; e.target = enq_pred_target1; e.pht = enq_pht_index1;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("count", count, sz);
    chk("enq_ready", enq_ready, (8 - sz) >= 2);
    chk("deq_valid0", deq_valid0, sz >= 1);
    chk("deq_valid1", deq_valid1, sz >= 2);
    if (sz >= 1) begin
      chk("pc0", deq_pc0, mq[0].pc);
      chk("instr0", deq_instr0, mq[0].instr);
      chk("taken0", deq_pred_taken0, mq[0].taken);
      chk("hit0", deq_btb_hit0, mq[0].hit);
      chk("target0", deq_pred_target0, mq[0].target);
      chk("pht0", deq_pht_index0, mq[0].pht);
      chk("ghr0", deq_ghr0, mq[0].ghr);
    end
    if (sz >= 2) begin
      chk("pc1", deq_pc1, mq[1].pc);
      chk("instr1", deq_instr1, mq[1].instr);
      chk("taken1", deq_pred_taken1, mq[1].taken);
      chk("hit1", deq_btb_hit1, mq[1].hit);
      chk("target1", deq_pred_target1, mq[1].target);
      chk("pht1", deq_pht_index1, mq[1].pht);
      chk("ghr1", deq_ghr1, mq[1].ghr);
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_model();
  endtask

  task automatic idle();
    flush = 1'b0; enq_valid = 1'b0; enq_slot1_valid = 1'b0; deq_pop = 2'd0;
  endtask

  task automatic set_enq(input logic [31:0] pc, input logic s1);
    enq_valid = 1'b1; enq_pc = pc; enq_slot1_valid = s1;
    enq_instr0 = $urandom; enq_instr1 = $urandom;
    enq_pred_taken0 = 1'($urandom); enq_pred_taken1 = 1'($urandom);
    enq_btb_hit0 = 1'($urandom); enq_btb_hit1 = 1'($urandom);
    enq_pred_target0 = $urandom; enq_pred_target1 = $urandom;
    enq_pht_index0 = 9'($urandom); enq_pht_index1 = 9'($urandom);
    enq_ghr = 9'($urandom);
  endtask

  task automatic do_flush();
    idle(); flush = 1'b1; tick(); idle();
  endtask

  task automatic async_pulse();
    idle();
    #2 reset = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_valid0", deq_valid0, 0);
    mq.delete();
    @(negedge CLK);
    check_model();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    set_enq(32'h0, 1'b0);
    enq_valid = 1'b0;
    @(negedge CLK);
    chk("rst_count", count, 0);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_valid0", deq_valid0, 0);
    chk("rst_valid1", deq_valid1, 0);
    chk("rst_payload0", {deq_pc0, deq_instr0}, 64'h0);
    chk("rst_payload1", {deq_pc1, deq_instr1}, 64'h0);
    chk("rst_meta0", {deq_pred_taken0, deq_btb_hit0, deq_pred_target0, deq_pht_index0, deq_ghr0}, 64'h0);
    chk("rst_meta1", {deq_pred_taken1, deq_btb_hit1, deq_pred_target1, deq_pht_index1, deq_ghr1}, 64'h0);
    reset = 1'b1;

    // First bundle
    set_enq(32'h100, 1'b1);
    enq_instr0 = 32'h0000_0013; enq_instr1 = 32'h0010_0093;
    tick(); idle();
    chk("t1_valid0", deq_valid0, 1);
    chk("t1_valid1", deq_valid1, 1);
    chk("t1_pc0", deq_pc0, 32'h100);
    chk("t1_pc1", deq_pc1, 32'h104);
    chk("t1_instr0", deq_instr0, 32'h13);
    chk("t1_instr1", deq_instr1, 32'h0010_0093);
    chk("t1_count", count, 2);

    // Fill to DEPTH, then a dropped fifth bundle
    do_flush();
    for (int i = 0; i < 4; i++) begin set_enq(32'h1000 + 32'(16 * i), 1'b1); tick(); end
    idle();
    chk("t2_count", count, 8);
    chk("t2_ready", enq_ready, 0);
    set_enq(32'h9000, 1'b1); tick(); idle();
    chk("t2_drop_count", count, 8);
    chk("t2_drop_pc0", deq_pc0, 32'h1000);

    // count=7: pop 2 + enq 2 -> enqueue dropped
    do_flush();
    for (int i = 0; i < 3; i++) begin set_enq(32'h2000 + 32'(16 * i), 1'b1); tick(); end
    set_enq(32'h3000, 1'b0); tick(); idle();
    chk("t3_count7", count, 7);
    chk("t3_ready7", enq_ready, 0);
    set_enq(32'h5000, 1'b1); deq_pop = 2'd2; tick(); idle();
    chk("t3_count5", count, 5);
    chk("t3_pc0", deq_pc0, 32'h2010);
    // count=6 with tail at 7: pop 2 + enq 2 wraps the tail through index 0
    do_flush();
    for (int i = 0; i < 3; i++) begin set_enq(32'h2000 + 32'(16 * i), 1'b1); tick(); end
    set_enq(32'h3000, 1'b0); deq_pop = 2'd1; tick(); idle();
    chk("t3_count6", count, 6);
    chk("t3_ready6", enq_ready, 1);
    set_enq(32'h4000, 1'b1); deq_pop = 2'd2; tick(); idle();
    chk("t3_count6b", count, 6);
    chk("t3_pc0b", deq_pc0, 32'h2014);
    deq_pop = 2'd2; tick(); tick(); idle();
    chk("t3_wrap_pc0", deq_pc0, 32'h4000);
    chk("t3_wrap_pc1", deq_pc1, 32'h4004);
    deq_pop = 2'd3; tick(); idle();
    chk("t3_drained", count, 0);

    // Single-slot taken bundle
    set_enq(32'h600, 1'b0); enq_pred_taken0 = 1'b1; enq_pred_target0 = 32'h200;
    tick(); idle();
    chk("t4_count", count, 1);
    chk("t4_valid1", deq_valid1, 0);
    chk("t4_taken0", deq_pred_taken0, 1);
    chk("t4_target0", deq_pred_target0, 32'h200);

    // Over-pop clamps
    deq_pop = 2'd2; tick(); idle();
    chk("t5_count", count, 0);
    chk("t5_valid0", deq_valid0, 0);
    set_enq(32'h500, 1'b1); tick(); idle();
    chk("t5_pc0", deq_pc0, 32'h500);
    chk("t5_count2", count, 2);
    set_enq(32'hFFFF_FFFC, 1'b1); tick(); idle();
    deq_pop = 2'd2; tick(); idle();
    chk("t5_pcwrap0", deq_pc0, 32'hFFFF_FFFC);
    chk("t5_pcwrap1", deq_pc1, 32'h0);

    // Flush beats simultaneous enq/deq
    set_enq(32'h700, 1'b1); tick();
    set_enq(32'h710, 1'b0); tick(); idle();
    chk("t6_count5", count, 5);
    set_enq(32'h800, 1'b1); deq_pop = 2'd2; flush = 1'b1; tick(); idle();
    chk("t6_count", count, 0);
    chk("t6_valid0", deq_valid0, 0);
    chk("t6_ready", enq_ready, 1);
    set_enq(32'h900, 1'b1); tick(); tick(); idle();
    chk("t6_pre_rst", count, 4);
    async_pulse();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_pulse();
      end else begin
        if ($urandom_range(0, 9) < 7) set_enq($urandom, 1'($urandom));
        else enq_valid = 1'b0;
        deq_pop = 2'($urandom_range(0, 3));
        flush = ($urandom_range(0, 49) == 0);
        tick();
      end
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
